// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and helpers for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; clamped to 1 so a degenerate WIDTH never yields a zero-width vector
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fsub_cell.sv
// rtl/fsub_cell.sv - combinational 1-bit full subtractor cell
module fsub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // With bin=0 this reduces to the half subtractor: d=a^b, bout=~a&b
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial subtractor diff = a - b - bin
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_sh_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             finish;

    fsub_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB
    assign d_sh_next = {cell_d, d_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            d_sh  <= '0;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= d_sh_next;
            br   <= cell_bout;
            cnt  <= cnt + 1'b1;
            if (finish) begin
                diff <= d_sh_next;
                bout <= cell_bout;
                zero <= (d_sh_next == '0);
                // Sign test uses only the operand signs; bin is deliberately left out
                ovf  <= (a_msb != b_msb) && (d_sh_next[WIDTH-1] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 2, 8 and 32
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        bin_in;
    int          sel;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        start2, start8, start32;
    logic        busy2, done2, bout2, ovf2, zero2;
    logic        busy8, done8, bout8, ovf8, zero8;
    logic        busy32, done32, bout32, ovf32, zero32;
    logic [1:0]  diff2;
    logic [7:0]  diff8;
    logic [31:0] diff32;

    logic        obs_busy, obs_done, obs_bout, obs_ovf, obs_zero;
    logic [31:0] obs_diff;

    always #5 clk = ~clk;

    assign start2  = start && (sel == 2);
    assign start8  = start && (sel == 8);
    assign start32 = start && (sel == 32);

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a_in[1:0]), .b(b_in[1:0]), .bin(bin_in),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2), .zero(zero2)
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a_in), .b(b_in), .bin(bin_in),
        .busy(busy32), .done(done32), .diff(diff32), .bout(bout32), .ovf(ovf32), .zero(zero32)
    );

    always_comb begin
        obs_busy = 1'b0;
        obs_done = 1'b0;
        obs_diff = '0;
        obs_bout = 1'b0;
        obs_ovf  = 1'b0;
        obs_zero = 1'b0;
        case (sel)
            2:  begin obs_busy = busy2;  obs_done = done2;  obs_diff = 32'(diff2);
                      obs_bout = bout2;  obs_ovf = ovf2;    obs_zero = zero2;  end
            8:  begin obs_busy = busy8;  obs_done = done8;  obs_diff = 32'(diff8);
                      obs_bout = bout8;  obs_ovf = ovf8;    obs_zero = zero8;  end
            32: begin obs_busy = busy32; obs_done = done32; obs_diff = diff32;
                      obs_bout = bout32; obs_ovf = ovf32;   obs_zero = zero32; end
            default: ;
        endcase
    end

    // Reference: plain integer arithmetic on the unsigned and signed readings of the operands
    function automatic logic [34:0] ref_sub(input int w, input logic [31:0] av, input logic [31:0] bv,
                                            input logic bi);
        longint full, half, ua, ub, sa, sb, s, bl;
        logic [31:0] d;
        full = longint'(1) << w;
        half = full >> 1;
        bl   = bi ? longint'(1) : longint'(0);
        ua   = longint'(av) & (full - 1);
        ub   = longint'(bv) & (full - 1);
        d    = 32'((ua - ub - bl) & (full - 1));
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        s    = sa - sb - bl;
        return {d, (ua < ub + bl), (s < -half || s >= half), (d == 32'd0)};
    endfunction

    // Drives one operation on the selected instance; called and returns at posedge+1
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic bi,
                          input bit poke, output int lat, output int busy_n, output bit held,
                          output logic [34:0] res, output int tail_act);
        logic [31:0] prev;
        prev   = obs_diff;
        a_in   = av;
        b_in   = bv;
        bin_in = bi;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = poke;
        a_in   = $urandom;
        b_in   = $urandom;
        bin_in = 1'($urandom);
        lat    = 0;
        busy_n = 0;
        held   = 1'b1;
        while (!obs_done && lat <= w + 4) begin
            if (obs_busy) busy_n++;
            if (obs_diff !== prev) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res      = {obs_diff, obs_bout, obs_ovf, obs_zero};
        tail_act = 0;
        for (int i = 0; i < w + 3; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (obs_busy || obs_done) tail_act++;
        end
    endtask

    task automatic test_reset();
        int ws[3];
        ws = '{2, 8, 32};
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0; sel = 8;
        repeat (3) @(posedge clk);
        #1;
        foreach (ws[i]) begin
            sel = ws[i];
            #1;
            n_tests++;
            if ({obs_busy, obs_done, obs_diff, obs_bout, obs_ovf, obs_zero} !== 37'd0) begin
                n_fail++;
                $display("FAIL reset_w%0d got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b exp all 0",
                         ws[i], obs_busy, obs_done, obs_diff, obs_bout, obs_ovf, obs_zero);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed(input int w);
        logic [7:0]  ta[6];
        logic [7:0]  tb_[6];
        logic        tbin[6];
        logic [34:0] k8[6];
        logic [34:0] res, exp;
        int lat, busy_n, tail;
        bit held;
        ta   = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'h2A};
        tb_  = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'h2A};
        tbin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        k8   = '{{32'h02, 3'b000}, {32'hFE, 3'b100}, {32'h7F, 3'b010},
                 {32'h80, 3'b110}, {32'hFF, 3'b100}, {32'h00, 3'b001}};
        sel = w;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            run_op(w, 32'(ta[i]), 32'(tb_[i]), tbin[i], 1'b0, lat, busy_n, held, res, tail);
            exp = (w == 8) ? k8[i] : ref_sub(w, 32'(ta[i]), 32'(tb_[i]), tbin[i]);
            n_tests++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL directed_w%0d_%0d got {diff,bout,ovf,zero}=%h exp %h", w, i, res, exp);
            end
            n_tests++;
            if (lat != w || busy_n != w || tail != 0) begin
                n_fail++;
                $display("FAIL timing_w%0d_%0d got latency=%0d busy_cycles=%0d tail=%0d exp %0d %0d 0",
                         w, i, lat, busy_n, tail, w, w);
            end
            n_tests++;
            if (!held) begin
                n_fail++;
                $display("FAIL hold_w%0d_%0d got diff changed during RUN exp held", w, i);
            end
        end
    endtask

    task automatic test_exhaustive_w2();
        logic [34:0] res, exp;
        int lat, busy_n, tail;
        bit held;
        sel = 2;
        @(posedge clk); #1;
        for (int av = 0; av < 4; av++)
            for (int bv = 0; bv < 4; bv++)
                for (int bi = 0; bi < 2; bi++) begin
                    run_op(2, 32'(av), 32'(bv), 1'(bi), 1'b0, lat, busy_n, held, res, tail);
                    exp = ref_sub(2, 32'(av), 32'(bv), 1'(bi));
                    n_tests++;
                    if (res !== exp || lat != 2) begin
                        n_fail++;
                        $display("FAIL exhaustive_w2 a=%0d b=%0d bin=%0d got %h lat=%0d exp %h lat=2",
                                 av, bv, bi, res, lat, exp);
                    end
                end
    endtask

    task automatic test_random(input int w, input int n);
        logic [34:0] res, exp;
        logic [31:0] av, bv;
        logic bi;
        int lat, busy_n, tail;
        bit held;
        sel = w;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            av = $urandom;
            bv = $urandom;
            bi = 1'($urandom);
            run_op(w, av, bv, bi, 1'b0, lat, busy_n, held, res, tail);
            exp = ref_sub(w, av, bv, bi);
            n_tests++;
            if (res !== exp || lat != w || !held) begin
                n_fail++;
                $display("FAIL random_w%0d a=%h b=%h bin=%b got %h lat=%0d held=%b exp %h lat=%0d held=1",
                         w, av, bv, bi, res, lat, held, exp, w);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [34:0] res, exp;
        int lat, busy_n, tail;
        bit held;
        sel = 8;
        @(posedge clk); #1;
        run_op(8, 32'h0000_00C3, 32'h0000_0044, 1'b1, 1'b1, lat, busy_n, held, res, tail);
        exp = ref_sub(8, 32'h0000_00C3, 32'h0000_0044, 1'b1);
        n_tests++;
        if (res !== exp) begin
            n_fail++;
            $display("FAIL ignore_start_result got %h exp %h", res, exp);
        end
        n_tests++;
        if (lat != 8 || tail != 0) begin
            n_fail++;
            $display("FAIL ignore_start_pulses got latency=%0d extra_active=%0d exp 8 0", lat, tail);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [34:0] res;
        int lat, busy_n, tail, act;
        bit held;
        sel = 8;
        @(posedge clk); #1;
        run_op(8, 32'h03, 32'h05, 1'b0, 1'b0, lat, busy_n, held, res, tail);
        a_in = 32'h55; b_in = 32'h11; bin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if ({obs_busy, obs_done, obs_diff, obs_bout, obs_ovf, obs_zero} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run got busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b exp all 0",
                     obs_busy, obs_done, obs_diff, obs_bout, obs_ovf, obs_zero);
        end
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (obs_busy || obs_done) act++;
        end
        n_tests++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL reset_mid_run_quiet got %0d active cycles exp 0", act);
        end
        run_op(8, 32'h10, 32'h01, 1'b0, 1'b0, lat, busy_n, held, res, tail);
        n_tests++;
        if (res !== {32'h0F, 3'b000}) begin
            n_fail++;
            $display("FAIL after_reset_op got %h exp %h", res, {32'h0F, 3'b000});
        end
    endtask

    task automatic test_reset_start();
        sel = 8;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; a_in = 32'h9; b_in = 32'h1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_with_start got busy=%b done=%b exp 0 0", obs_busy, obs_done);
        end
    endtask

    task automatic test_back_to_back();
        int wait_n, gap;
        sel = 8;
        @(posedge clk); #1;
        a_in = 32'h40; b_in = 32'h21; bin_in = 1'b0; start = 1'b1;
        wait_n = 0;
        while (!obs_done && wait_n < 40) begin
            @(posedge clk); #1;
            wait_n++;
        end
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (!obs_done && gap < 40);
        start = 1'b0;
        n_tests++;
        if (gap != 10) begin
            n_fail++;
            $display("FAIL back_to_back_period got %0d cycles exp 10", gap);
        end
        n_tests++;
        if (obs_diff !== 32'h1F) begin
            n_fail++;
            $display("FAIL back_to_back_result got %h exp %h", obs_diff, 32'h1F);
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed(8);
        test_ignore_start();
        test_reset_mid_run();
        test_reset_start();
        test_back_to_back();
        test_directed(2);
        test_exhaustive_w2();
        test_directed(32);
        test_random(8, 24);
        test_random(32, 12);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
